// File: rtl/uart_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_receiver_if
// Description : Frame output channel of the UART frame receiver. It carries
//               one completed measurement frame and a valid/ready handshake.
//                 out_data  - completed frame, byte k in bits [8k+7:8k]
//                 out_valid - out_data holds an unconsumed frame
//                 out_ready - consumer accepts when out_valid && out_ready
//               The master modport is the receiver; the slave modport is the
//               consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_receiver_if #(
  parameter int FRAME_BYTES = 7
);
  logic [8*FRAME_BYTES-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_receiver
// Description : Receives 8N1 bytes from the sensor board UART stream, locks
//               onto the all-ones sync frame and reassembles multi-byte
//               measurement frames (LSB byte first) onto a valid/ready output.
// Ports       : clk          - system clock
//               rst          - synchronous active-high reset
//               i_rx         - UART line, asynchronous, idle high
//               o_frame      - frame output channel (data/valid/ready)
//               o_locked     - frame alignment established
//               o_sync_pulse - 1-cycle pulse per sync frame received
//               o_frame_err  - 1-cycle pulse on a bad stop bit
//               o_overrun    - 1-cycle pulse when a completed frame is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_receiver #(
  parameter int CLKS_PER_BIT = 208,
  parameter int FRAME_BYTES  = 7,
  parameter int TIMEOUT_BITS = 20
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_rx,
  uart_frame_receiver_if.master o_frame,
  output logic                  o_locked,
  output logic                  o_sync_pulse,
  output logic                  o_frame_err,
  output logic                  o_overrun
);

  localparam int c_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W     = $clog2(FRAME_BYTES);
  localparam int c_FRAME_W   = 8 * FRAME_BYTES;
  localparam int c_TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int c_TO_W      = $clog2(c_TO_CYCLES);

  localparam logic [c_CNT_W-1:0] c_HALF_BIT = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_BIT = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_BYTES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser. Flops reset to the idle (high) line level.
  // --------------------------------------------------------------------------
  logic       r_rx_meta;
  logic       r_rxs;
  logic [1:0] r_flush;
  logic       r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_flush   <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rxs     <= r_rx_meta;
      r_flush   <= {r_flush[0], 1'b1};
      // Start detection is held off until the real line has been seen high
      // after reset, so a byte cut by reset cannot be mistaken for a start.
      if (r_flush[1] && r_rxs) begin
        r_armed <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bit-level FSM
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_baud;
  logic [c_CNT_W-1:0] w_baud_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               w_byte_done;
  logic               w_stop_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_stop_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (r_armed && !r_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Re-check the start bit at its centre; a high level is a glitch.
        if (r_baud == c_HALF_BIT) begin
          w_baud_nxt = '0;
          if (r_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (r_baud == c_FULL_BIT) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {r_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_baud == c_FULL_BIT) begin
          w_baud_nxt = '0;
          if (r_rxs) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_err  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_baud_nxt = '0;
        if (r_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Alignment, frame assembly, timeout and output register
  // --------------------------------------------------------------------------
  logic [c_FRAME_W-1:0] r_shift_buf;
  logic [c_FRAME_W-1:0] w_frame_cand;
  logic [c_IDX_W-1:0]   r_byte_idx;
  logic [c_IDX_W-1:0]   r_ff_count;
  logic [c_TO_W-1:0]    r_idle_cnt;
  logic [c_FRAME_W-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_locked;
  logic                 r_sync_pulse;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_idle_run;
  logic                 w_timeout;
  logic                 w_frame_done;
  logic                 w_offer;

  // Frame buffer with the byte just received merged in, so a completed frame
  // can be loaded into the output register on the byte_done edge itself.
  always_comb begin
    w_frame_cand                      = r_shift_buf;
    w_frame_cand[8*r_byte_idx +: 8]   = r_shift;
  end

  assign w_idle_run   = r_locked && (r_byte_idx != '0) && r_rxs;
  assign w_timeout    = w_idle_run && (r_idle_cnt == c_TO_LAST);
  assign w_frame_done = w_byte_done && r_locked && (r_byte_idx == c_LAST_IDX);
  assign w_offer      = w_frame_done && (w_frame_cand != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_buf  <= '0;
      r_byte_idx   <= '0;
      r_ff_count   <= '0;
      r_idle_cnt   <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_pulse <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync_pulse <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;

      if (w_idle_run && !w_timeout) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end

      if (w_stop_err) begin
        r_frame_err <= 1'b1;
        r_ff_count  <= '0;
        if (r_locked) begin
          r_locked   <= 1'b0;
          r_byte_idx <= '0;
        end
      end else if (w_byte_done) begin
        if (!r_locked) begin
          // Hunt for FRAME_BYTES consecutive 0xFF bytes.
          if (r_shift == 8'hFF) begin
            if (r_ff_count == c_LAST_IDX) begin
              r_locked     <= 1'b1;
              r_sync_pulse <= 1'b1;
              r_byte_idx   <= '0;
              r_ff_count   <= '0;
            end else begin
              r_ff_count <= r_ff_count + 1'b1;
            end
          end else begin
            r_ff_count <= '0;
          end
        end else begin
          r_shift_buf <= w_frame_cand;
          if (r_byte_idx == c_LAST_IDX) begin
            r_byte_idx <= '0;
            if (w_frame_cand == '1) begin
              r_sync_pulse <= 1'b1;
            end
          end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
          end
        end
      end else if (w_timeout) begin
        r_byte_idx <= '0;
      end

      // Single-entry output; a frame arriving while the held one is being
      // accepted replaces it without a bubble.
      if (w_offer) begin
        if (!r_out_valid || o_frame.out_ready) begin
          r_out_data  <= w_frame_cand;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && o_frame.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_frame.out_data  = r_out_data;
  assign o_frame.out_valid = r_out_valid;
  assign o_locked          = r_locked;
  assign o_sync_pulse      = r_sync_pulse;
  assign o_frame_err       = r_frame_err;
  assign o_overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_receiver
// Description : Scoreboard bench for uart_frame_receiver. A byte-level model
//               of the stream (lock hunting, frame grouping, drop rules)
//               pushes expected frames; a monitor pops on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_receiver;
  localparam int CPB = 16;
  localparam int TOB = 20;
  localparam int FB  = 7;
  localparam int LATENCY = 2 + CPB/2 + 9*CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic o_locked, o_sync_pulse, o_frame_err, o_overrun;

  always #5 clk = ~clk;

  uart_frame_receiver_if #(.FRAME_BYTES(FB)) u_if ();

  uart_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (FB),
    .TIMEOUT_BITS(TOB)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_frame     (u_if),
    .o_locked    (o_locked),
    .o_sync_pulse(o_sync_pulse),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [55:0] exp_q[$];
  logic [7:0]  m_part[$];
  bit          m_locked = 0;
  int          m_run    = 0;
  bit          m_held   = 0;
  int          exp_sync = 0, exp_ferr = 0, exp_ovr = 0;
  int          obs_sync = 0, obs_ferr = 0, obs_ovr = 0;

  task automatic model_byte(input logic [7:0] b);
    logic [55:0] f;
    if (!m_locked) begin
      if (b == 8'hFF) begin
        m_run++;
        if (m_run == FB) begin
          m_locked = 1; m_run = 0; exp_sync++; m_part.delete();
        end
      end else begin
        m_run = 0;
      end
    end else begin
      m_part.push_back(b);
      if (m_part.size() == FB) begin
        f = '0;
        for (int k = 0; k < FB; k++) f = f | (56'(m_part[k]) << (8*k));
        m_part.delete();
        if (f == {56{1'b1}}) exp_sync++;
        else if (m_held) exp_ovr++;
        else begin
          exp_q.push_back(f);
          if (!u_if.out_ready) m_held = 1;
        end
      end
    end
  endtask

  task automatic model_ferr();
    exp_ferr++;
    m_run = 0;
    if (m_locked) begin
      m_locked = 0; m_part.delete();
    end
  endtask

  // ---------------- driver ----------------
  int unsigned lat_start = 0, lat_cycles = 0;
  bit          lat_arm = 0, lat_seen = 0;

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    if (n >= TOB + 2 && m_locked) m_part.delete();
    repeat (n) bit_time(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input bit meas);
    if (good) model_byte(b); else model_ferr();
    if (meas) begin lat_start = cyc; lat_arm = 1; lat_seen = 0; end
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(good);
    if (!good) bit_time(1'b1);
  endtask

  task automatic send_gap_byte(input logic [7:0] b);
    send_byte(b, 1'b1, 1'b0);
    idle_bits(int'($urandom_range(0, 2)));
  endtask

  task automatic send_sync();
    for (int i = 0; i < FB; i++) send_gap_byte(8'hFF);
  endtask

  task automatic send_rand_frame();
    for (int i = 0; i < FB; i++) send_gap_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic checkpoint(input string name);
    idle_bits(2);
    check({name, "_sync"},   64'(obs_sync), 64'(exp_sync));
    check({name, "_ferr"},   64'(obs_ferr), 64'(exp_ferr));
    check({name, "_ovr"},    64'(obs_ovr),  64'(exp_ovr));
    check({name, "_locked"}, 64'(o_locked), 64'(m_locked));
    check({name, "_drain"},  64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic [55:0] prev_data;
  bit          prev_hold = 0, prev_valid = 0;
  int          vlen = 0, last_vlen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0; prev_valid = 0; vlen = 0;
    end else begin
      if (o_sync_pulse) obs_sync++;
      if (o_frame_err)  obs_ferr++;
      if (o_overrun)    obs_ovr++;
      if (u_if.out_valid && prev_hold) check("hold_stable", 64'(u_if.out_data), 64'(prev_data));
      if (u_if.out_valid && !prev_valid && lat_arm) begin
        lat_cycles = cyc - lat_start; lat_arm = 0; lat_seen = 1;
      end
      if (u_if.out_valid) vlen++;
      else if (vlen != 0) begin last_vlen = vlen; vlen = 0; end
      if (u_if.out_valid && u_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_unexpected: got %0h, expected no frame", u_if.out_data);
        end else begin
          check("frame", 64'(u_if.out_data), 64'(exp_q.pop_front()));
        end
      end
      prev_hold  = u_if.out_valid && !u_if.out_ready;
      prev_valid = u_if.out_valid;
      prev_data  = u_if.out_data;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid",  64'(u_if.out_valid), 64'd0);
    check("rst_data",   64'(u_if.out_data),  64'd0);
    check("rst_locked", 64'(o_locked),       64'd0);
    check("rst_pulses", 64'({o_sync_pulse, o_frame_err, o_overrun}), 64'd0);
    @(posedge clk); #1;
    idle_bits(2);

    // Lock and a known frame with latency measurement on the last byte.
    send_sync();
    check("lock_after_sync", 64'(o_locked), 64'd1);
    for (int i = 1; i <= FB; i++) begin
      send_byte(8'(i), 1'b1, i == FB);
      idle_bits(1);
    end
    check("latency_seen", 64'(lat_seen), 64'd1);
    n_chk++;
    if (lat_cycles + 1 < LATENCY || lat_cycles > LATENCY + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d, expected %0d +/-1", lat_cycles, LATENCY);
    end
    check("valid_len", 64'(last_vlen), 64'd1);
    checkpoint("lock");

    // Random frames with ready held high.
    for (int f = 0; f < 3; f++) send_rand_frame();
    checkpoint("random");

    // Backpressure: second frame dropped, first held stable.
    u_if.out_ready = 1'b0;
    send_rand_frame();
    send_rand_frame();
    idle_bits(2);
    check("bp_valid", 64'(u_if.out_valid), 64'd1);
    check("bp_data",  64'(u_if.out_data),  64'(exp_q[0]));
    check("bp_ovr",   64'(obs_ovr),        64'(exp_ovr));
    u_if.out_ready = 1'b1;
    m_held = 0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_released", 64'(u_if.out_valid), 64'd0);
    checkpoint("backpressure");

    // Framing error mid-frame, then pre-lock junk and relock.
    for (int i = 0; i < 3; i++) send_gap_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle_bits(1);
    check("ferr_unlocked", 64'(o_locked), 64'd0);
    send_gap_byte(8'h12);
    for (int i = 0; i < 5; i++) send_gap_byte(8'hFF);
    send_gap_byte(8'h00);
    check("junk_no_lock", 64'(o_locked), 64'd0);
    send_sync();
    for (int i = 0; i < FB; i++) send_gap_byte(8'hAA);
    send_rand_frame();
    checkpoint("relock");

    // Short low glitch on an idle line.
    rx = 1'b0;
    repeat (CPB/4) @(posedge clk);
    #1;
    idle_bits(3);
    checkpoint("glitch");

    // Partial frame discarded by idle timeout.
    for (int i = 0; i < 4; i++) send_gap_byte(8'($urandom_range(0, 255)));
    idle_bits(25);
    send_rand_frame();
    checkpoint("timeout");

    // Reset pulse during data bit 3 of a byte.
    m_locked = 0; m_run = 0; m_part.delete(); m_held = 0;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b0);
    rx = 1'b0;
    repeat (CPB/2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",  64'(u_if.out_valid), 64'd0);
    check("mid_rst_data",   64'(u_if.out_data),  64'd0);
    check("mid_rst_locked", 64'(o_locked),       64'd0);
    repeat (CPB/2 - 1) @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) bit_time(1'b0);
    bit_time(1'b1);
    idle_bits(2);
    send_sync();
    send_rand_frame();
    send_rand_frame();
    checkpoint("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
